run_detector: RTL and testbench

Parametrised run-length detector on a single serial input `w`. It generalises the fixed 3-bit Moore sequence recogniser: the run length is set by a parameter, a mode input selects which polarity is detected, a sample enable gates input sampling, and a saturating counter records detections. The current run state is exposed as a binary output for display and debug, as in the earlier block.

---
 rtl/run_detector.sv | 113 +++++++++++
 tb/tb_run_detector.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/run_detector.sv
// ----------------------------------------------------------------------------
// run_detector
//
// Purpose:
//   Run-length detector on a serial bit stream. Tracks the length and value
//   of the current run of equal enabled samples and raises a registered
//   detect flag once the run reaches RUN_LEN samples of a selected polarity.
//   A saturating counter records every detection, including overlapping
//   detections from samples beyond RUN_LEN.
//
// Parameters:
//   RUN_LEN       - samples in a run needed for a detection (2..255)
//   CNT_W         - width of match_count (>= 1)
//
// Ports:
//   clk           in   clock, all state updates on the rising edge
//   reset         in   synchronous active-high reset, highest priority
//   w             in   serial data bit, sampled only when en = 1
//   en            in   sample enable; run state and match_count hold when 0
//   mode[1:0]     in   00 either polarity, 01 ones only, 10 zeros only,
//                      11 detection disabled
//   z             out  registered detect flag
//   binaryoutput  out  current run length (0 = no sample since reset)
//   run_val       out  value of the current run
//   match_count   out  saturating detection count
// ----------------------------------------------------------------------------
module run_detector #(
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = 8,
    localparam int RW     = $clog2(RUN_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             w,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic             z,
    output logic [RW-1:0]    binaryoutput,
    output logic             run_val,
    output logic [CNT_W-1:0] match_count
);

    localparam logic [RW-1:0] RUN_LEN_C = RW'(RUN_LEN);
    localparam logic [RW-1:0] ONE_C     = RW'(1);

    logic [RW-1:0]    run_len_q, run_len_d;
    logic             run_val_q, run_val_d;
    logic             z_q, z_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             mode_ok;

    // Run tracking: the run length saturates at RUN_LEN so that every extra
    // equal sample keeps the detect condition true and counts again.
    always_comb begin
        run_len_d = run_len_q;
        run_val_d = run_val_q;
        if (en) begin
            if (run_len_q == '0) begin
                // First sample after reset starts a run.
                run_len_d = ONE_C;
                run_val_d = w;
            end else if (w == run_val_q) begin
                if (run_len_q != RUN_LEN_C) begin
                    run_len_d = run_len_q + ONE_C;
                end
            end else begin
                run_len_d = ONE_C;
                run_val_d = w;
            end
        end
    end

    // Polarity filter, evaluated on the run value that will be registered.
    always_comb begin
        mode_ok = 1'b0;
        case (mode)
            2'b00:   mode_ok = 1'b1;
            2'b01:   mode_ok = run_val_d;
            2'b10:   mode_ok = ~run_val_d;
            default: mode_ok = 1'b0;
        endcase
    end

    // z is recomputed every cycle, so a mode change while en = 0 still moves
    // z; the counter only advances on enabled cycles.
    always_comb begin
        z_d     = (run_len_d == RUN_LEN_C) && mode_ok;
        count_d = count_q;
        if (en && z_d && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_len_q <= '0;
            run_val_q <= 1'b0;
            z_q       <= 1'b0;
            count_q   <= '0;
        end else begin
            run_len_q <= run_len_d;
            run_val_q <= run_val_d;
            z_q       <= z_d;
            count_q   <= count_d;
        end
    end

    assign z            = z_q;
    assign binaryoutput = run_len_q;
    assign run_val      = run_val_q;
    assign match_count  = count_q;

endmodule

// File: tb/tb_run_detector.sv
// ----------------------------------------------------------------------------
// tb_run_detector
//
// Directed bench for run_detector (RUN_LEN = 4, CNT_W = 8). Each step drives
// one cycle of inputs, pushes the expected post-edge outputs to a queue, and
// after the edge pops the entry and compares all four outputs.
// ----------------------------------------------------------------------------
module tb_run_detector;

    localparam int RUN_LEN = 4;
    localparam int CNT_W   = 8;
    localparam int RW      = $clog2(RUN_LEN + 1);

    logic             clk;
    logic             reset;
    logic             w;
    logic             en;
    logic [1:0]       mode;
    logic             z;
    logic [RW-1:0]    binaryoutput;
    logic             run_val;
    logic [CNT_W-1:0] match_count;

    typedef struct {
        int bo;
        int rv;
        int z;
        int cnt;
    } exp_t;

    exp_t  exp_q[$];
    int    tests_run;
    int    tests_failed;
    string scen;
    int    step_no;

    run_detector #(
        .RUN_LEN(RUN_LEN),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .w           (w),
        .en          (en),
        .mode        (mode),
        .z           (z),
        .binaryoutput(binaryoutput),
        .run_val     (run_val),
        .match_count (match_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input int expv);
        tests_run++;
        assert (obs === 32'(expv))
        else begin
            tests_failed++;
            $error("FAIL %s step %0d %s: observed %0d expected %0d",
                   scen, step_no, tag, obs, expv);
        end
    endtask

    // One clock cycle: drive inputs, push expectation, compare after the edge.
    task automatic step(input logic r, input logic e, input logic wi,
                        input logic [1:0] m,
                        input int ebo, input int erv, input int ez, input int ecnt);
        exp_t ex;
        exp_t got;
        @(negedge clk);
        reset = r;
        en    = e;
        w     = wi;
        mode  = m;
        ex.bo  = ebo;
        ex.rv  = erv;
        ex.z   = ez;
        ex.cnt = ecnt;
        exp_q.push_back(ex);
        @(posedge clk);
        #1;
        step_no++;
        got = exp_q.pop_front();
        check("binaryoutput", 32'(binaryoutput), got.bo);
        check("run_val",      32'(run_val),      got.rv);
        check("z",            32'(z),            got.z);
        check("match_count",  32'(match_count),  got.cnt);
        $display("[TB] %s step %0d rst=%0b en=%0b w=%0b mode=%0b -> bo=%0d rv=%0b z=%0b cnt=%0d",
                 scen, step_no, r, e, wi, m, binaryoutput, run_val, z, match_count);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 2'b00, 0, 0, 0, 0);
    endtask

    initial begin
        int bo_e;
        int cnt_e;
        tests_run    = 0;
        tests_failed = 0;
        step_no      = 0;
        reset = 1'b1;
        en    = 1'b0;
        w     = 1'b0;
        mode  = 2'b00;

        // Basic detection and overlap
        scen = "basic";
        do_reset();
        step(0, 1, 1, 2'b00, 1, 1, 0, 0);
        step(0, 1, 1, 2'b00, 2, 1, 0, 0);
        step(0, 1, 1, 2'b00, 3, 1, 0, 0);
        step(0, 1, 1, 2'b00, 4, 1, 1, 1);
        step(0, 1, 1, 2'b00, 4, 1, 1, 2);
        step(0, 1, 1, 2'b00, 4, 1, 1, 3);

        // Run break
        scen = "break";
        do_reset();
        step(0, 1, 1, 2'b00, 1, 1, 0, 0);
        step(0, 1, 1, 2'b00, 2, 1, 0, 0);
        step(0, 1, 1, 2'b00, 3, 1, 0, 0);
        step(0, 1, 0, 2'b00, 1, 0, 0, 0);
        step(0, 1, 0, 2'b00, 2, 0, 0, 0);
        step(0, 1, 0, 2'b00, 3, 0, 0, 0);
        step(0, 1, 0, 2'b00, 4, 0, 1, 1);
        // Break from a saturated run drops z immediately
        step(0, 1, 1, 2'b00, 1, 1, 0, 1);

        // Mode filter
        scen = "mode";
        do_reset();
        step(0, 1, 0, 2'b01, 1, 0, 0, 0);
        step(0, 1, 0, 2'b01, 2, 0, 0, 0);
        step(0, 1, 0, 2'b01, 3, 0, 0, 0);
        step(0, 1, 0, 2'b01, 4, 0, 0, 0);
        step(0, 1, 0, 2'b01, 4, 0, 0, 0);
        step(0, 0, 0, 2'b10, 4, 0, 1, 0);
        step(0, 0, 0, 2'b11, 4, 0, 0, 0);
        step(0, 1, 0, 2'b11, 4, 0, 0, 0);
        step(0, 1, 0, 2'b10, 4, 0, 1, 1);

        // Enable gating
        scen = "enable";
        do_reset();
        step(0, 1, 1, 2'b00, 1, 1, 0, 0);
        step(0, 0, 1, 2'b00, 1, 1, 0, 0);
        step(0, 1, 1, 2'b00, 2, 1, 0, 0);
        step(0, 0, 1, 2'b00, 2, 1, 0, 0);
        step(0, 1, 1, 2'b00, 3, 1, 0, 0);
        step(0, 0, 0, 2'b00, 3, 1, 0, 0);
        step(0, 1, 1, 2'b00, 4, 1, 1, 1);
        // Disabled cycle with z held high must not count
        step(0, 0, 0, 2'b00, 4, 1, 1, 1);

        // Counter saturation
        scen = "saturate";
        do_reset();
        for (int i = 1; i <= 300; i++) begin
            bo_e  = (i < RUN_LEN) ? i : RUN_LEN;
            cnt_e = (i < RUN_LEN) ? 0 : i - (RUN_LEN - 1);
            if (cnt_e > 255) cnt_e = 255;
            step(0, 1, 1, 2'b00, bo_e, 1, (i >= RUN_LEN) ? 1 : 0, cnt_e);
        end

        // Reset mid-run, reset priority over en, multi-cycle reset
        scen = "reset";
        do_reset();
        step(0, 1, 1, 2'b00, 1, 1, 0, 0);
        step(0, 1, 1, 2'b00, 2, 1, 0, 0);
        step(0, 1, 1, 2'b00, 3, 1, 0, 0);
        step(1, 1, 1, 2'b00, 0, 0, 0, 0);
        step(1, 1, 1, 2'b00, 0, 0, 0, 0);
        step(0, 1, 1, 2'b00, 1, 1, 0, 0);
        step(0, 1, 1, 2'b00, 2, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
